// File: rtl/q_pkg.sv
// Shared types and constants for the queue_cntrl pop-side reader.
// The skid buffer depth also sets the credit limit on outstanding words.
package q_pkg;

    localparam int SKID_DEPTH = 2;

    // Skid occupancy; also wide enough for occupancy plus one in-flight pop.
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_MAX = occ_t'(SKID_DEPTH);

endpackage

// File: rtl/queue_reader_skid.sv
// Two-entry register FIFO holding words returned by the queue until
// downstream accepts them. Push and pop may happen in the same cycle.
module queue_reader_skid
    import q_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output occ_t         o_occ
);

    logic [W-1:0] r_mem [SKID_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    occ_t         r_occ;

    // NOTE: the entries are reset too, so o_data reads zero after reset;
    // at two entries that costs nothing worth avoiding.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + occ_t'(i_push) - occ_t'(i_pop);
        end
    end

    assign o_valid = (r_occ != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_occ   = r_occ;

endmodule

// File: rtl/queue_reader.sv
// Pop-side initiator for queue_cntrl: pops against the empty flag, captures
// read data one cycle later and presents it on a valid/ready interface.
module queue_reader
    import q_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         i_empty,
    output logic         o_pop,
    input  logic [W-1:0] i_pop_data,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready,
    output logic         o_idle
);

    logic r_inflight;
    occ_t w_occ;
    occ_t w_cnt;
    logic w_valid;
    logic w_deq;

    // Credits: a skid slot is owed to every word held or still on its way back.
    assign w_cnt = w_occ + occ_t'(r_inflight);
    assign w_deq = w_valid & i_ready;
    assign o_pop = ~arst & ~i_empty & ((w_cnt < OCC_MAX) | w_deq);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_pop;
        end
    end

    queue_reader_skid #(
        .W (W)
    ) u_skid (
        .clk         (clk),
        .arst        (arst),
        .i_push      (r_inflight),
        .i_push_data (i_pop_data),
        .i_pop       (w_deq),
        .o_valid     (w_valid),
        .o_data      (o_data),
        .o_occ       (w_occ)
    );

    assign o_valid = w_valid;
    assign o_idle  = ~r_inflight & (w_occ == '0);

endmodule

// File: tb/tb_queue_reader.sv
// Directed bench for queue_reader: a queue model feeds pops, a scoreboard
// checks order, and per-cycle invariants check valid/ready and credit rules.
module tb_queue_reader;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         arst;
    logic         i_empty;
    logic         o_pop;
    logic [W-1:0] i_pop_data;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         i_ready;
    logic         o_idle;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] src_q [$];
    logic [W-1:0] exp_q [$];
    logic         force_empty;
    logic         s_pop, s_valid, s_idle;
    logic [W-1:0] s_data;
    logic         prev_valid, prev_ready;
    logic [W-1:0] prev_data;
    int           delivered;
    int           cyc;

    always #5 clk = ~clk;

    queue_reader #(.W(W)) dut (
        .clk        (clk),
        .arst       (arst),
        .i_empty    (i_empty),
        .o_pop      (o_pop),
        .i_pop_data (i_pop_data),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .o_idle     (o_idle)
    );

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic load(input logic [W-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input logic ready);
        logic [W-1:0] want;
        i_ready = ready;
        i_empty = force_empty | (src_q.size() == 0);
        #1;
        s_pop   = o_pop;
        s_valid = o_valid;
        s_data  = o_data;
        s_idle  = o_idle;
        if (i_empty) check("no_pop_when_empty", W'(o_pop), 0);
        if (prev_valid && !prev_ready) begin
            check("valid_held", W'(o_valid), 1);
            check("data_held", o_data, prev_data);
        end
        check("occ_le_2", W'(dut.u_skid.r_occ <= 2), 1);
        if (o_valid && ready) begin
            check("deliver_expected", W'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check("deliver_order", o_data, want);
            end
            delivered++;
        end
        prev_valid = o_valid;
        prev_ready = ready;
        prev_data  = o_data;
        @(posedge clk);
        #1;
        if (s_pop) i_pop_data = (src_q.size() != 0) ? src_q.pop_front() : 32'hDEAD_BEEF;
        else       i_pop_data = 32'hBAD0_0000 ^ W'(cyc);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget, input bit rnd, input bit alt);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && src_q.size() == 0) break;
            if (alt) force_empty = i[0];
            cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        force_empty = 1'b0;
        check("drain_complete", W'(exp_q.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] exp_pop, exp_valid, exp_idle;
        int pops;
        int d0;

        arst        = 1'b1;
        i_empty     = 1'b1;
        i_ready     = 1'b0;
        i_pop_data  = '0;
        force_empty = 1'b0;
        prev_valid  = 1'b0;
        prev_ready  = 1'b0;
        prev_data   = '0;
        delivered   = 0;
        cyc         = 0;

        // Reset values, with a non-empty queue to show reset gates o_pop.
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_empty = 1'b0;
        #1;
        check("rst_pop", W'(o_pop), 0);
        check("rst_valid", W'(o_valid), 0);
        check("rst_data", o_data, 0);
        check("rst_idle", W'(o_idle), 1);
        check("rst_inflight", W'(dut.r_inflight), 0);
        check("rst_occ", W'(dut.u_skid.r_occ), 0);
        i_empty = 1'b1;
        arst    = 1'b0;

        // Four words, downstream always ready.
        for (int i = 0; i < 4; i++) load(32'hA000_0000 + W'(i));
        exp_pop   = 7'b0001111;
        exp_valid = 7'b0111100;
        exp_idle  = 7'b1000001;
        for (int c = 0; c < 7; c++) begin
            cycle(1'b1);
            check("t1_pop", W'(s_pop), W'(exp_pop[c]));
            check("t1_valid", W'(s_valid), W'(exp_valid[c]));
            check("t1_idle", W'(s_idle), W'(exp_idle[c]));
            if (c >= 2 && c <= 5) check("t1_data", s_data, 32'hA000_0000 + W'(c - 2));
        end

        // Five words, 10 cycles of backpressure, then release.
        for (int i = 0; i < 5; i++) load(32'hB000_0000 + W'(i));
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0);
            pops += int'(s_pop);
            if (c >= 2) begin
                check("t2_bp_valid", W'(s_valid), 1);
                check("t2_bp_data", s_data, 32'hB000_0000);
            end
        end
        check("t2_pop_count", W'(pops), 2);
        check("t2_occ_full", W'(dut.u_skid.r_occ), 2);
        check("t2_no_inflight", W'(dut.r_inflight), 0);
        cycle(1'b1);
        check("t2_pop_on_release", W'(s_pop), 1);
        check("t2_valid_release", W'(s_valid), 1);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1);
            check("t2_no_gap", W'(s_valid), 1);
        end
        cycle(1'b1);
        check("t2_idle_after", W'(s_idle), 1);
        check("t2_all_delivered", W'(exp_q.size()), 0);

        // Queue reports empty throughout while holding words.
        force_empty = 1'b1;
        for (int i = 0; i < 3; i++) load(32'hC000_0000 + W'(i));
        for (int c = 0; c < 20; c++) begin
            cycle(1'($urandom_range(0, 1)));
            check("t3_no_pop", W'(s_pop), 0);
            check("t3_no_valid", W'(s_valid), 0);
        end
        force_empty = 1'b0;
        drain(50, 1'b0, 1'b0);

        // Empty flag toggling every cycle, random ready.
        for (int i = 0; i < 12; i++) load(32'hE000_0000 + W'(i));
        drain(300, 1'b1, 1'b1);

        // Reset while one word is held and another is in flight.
        for (int i = 0; i < 6; i++) load(32'hF000_0000 + W'(i));
        cycle(1'b0);
        cycle(1'b0);
        check("t5_pre_inflight", W'(dut.r_inflight), 1);
        check("t5_pre_occ", W'(dut.u_skid.r_occ), 1);
        arst    = 1'b1;
        i_empty = 1'b0;
        #1;
        check("t5_rst_pop", W'(o_pop), 0);
        check("t5_rst_valid", W'(o_valid), 0);
        check("t5_rst_data", o_data, 0);
        check("t5_rst_idle", W'(o_idle), 1);
        @(posedge clk);
        #1;
        i_pop_data = 32'hBAD0_FFFF;
        @(negedge clk);
        arst       = 1'b0;
        prev_valid = 1'b0;
        exp_q      = src_q;
        cycle(1'b1);
        check("t5_pop_resumes", W'(s_pop), 1);
        drain(50, 1'b0, 1'b0);

        // 1000 words with 50% ready.
        d0 = delivered;
        for (int i = 0; i < 1000; i++) load((W'(i) * 32'h9E37_79B9) ^ 32'h1234_5678);
        drain(6000, 1'b1, 1'b0);
        check("t6_count", W'(delivered - d0), 1000);
        cycle(1'b1);
        check("t6_idle", W'(s_idle), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
